// File: rtl/pwm_multi.sv
// pwm_multi: several PWM channels driven by one shared period counter.
// The counter runs edge-aligned (sawtooth) or center-aligned (triangle).
// Each channel keeps a shadow duty that the host can write at any time.
// Shadow duties are copied into the active duties only at a period boundary,
// so every period is generated with one consistent set of duties.
// A write that lands on the boundary cycle itself goes straight into the
// active duty, so it is never lost or delayed by a whole period.

module pwm_multi #(
    parameter int N        = 8,
    parameter int CHANNELS = 4,
    parameter int AW       = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                step,
    input  logic [N-1:0]        period,
    input  logic                mode,
    input  logic                wr_ena,
    input  logic [AW-1:0]       wr_addr,
    input  logic [N-1:0]        wr_duty,
    output logic [CHANNELS-1:0] out,
    output logic                period_done
);

    // A single channel has no meaning for a shared-counter block.
    if (CHANNELS < 2) begin : g_bad_channels
        $error("pwm_multi: CHANNELS must be at least 2");
    end

    // Direction of the triangle in center-aligned mode.
    // Edge-aligned mode always counts up and leaves the direction at DIR_UP.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Shared timebase state.
    logic [N-1:0] r_counter;
    dir_t         r_dir;
    logic [N-1:0] r_period_a;   // period in force for the current period
    logic         r_mode_a;     // mode in force: 0 edge, 1 center
    logic         r_period_done;

    // Next-state values of the timebase.
    logic [N-1:0] w_counter_next;
    dir_t         w_dir_next;
    logic         w_boundary;       // this advance would close the period
    logic         w_advance;        // the counter moves on this edge
    logic         w_boundary_take;  // a boundary actually happens on this edge

    // The counter only moves when it is enabled and strobed.
    // While ena is low, step is ignored and the whole timebase holds.
    assign w_advance       = ena & step;
    assign w_boundary_take = w_advance & w_boundary;

    // Work out where the counter would go if it advanced this cycle.
    always_comb begin
        w_counter_next = r_counter;
        w_dir_next     = r_dir;
        w_boundary     = 1'b0;

        if (r_period_a == '0) begin
            // A zero period pins the counter at 0.
            // Every advance is then a boundary, in either mode.
            w_counter_next = '0;
            w_dir_next     = DIR_UP;
            w_boundary     = 1'b1;
        end else if (!r_mode_a) begin
            // Sawtooth: 0 .. P then back to 0.
            // The wrap to 0 is the boundary, which gives P+1 steps per period.
            if (r_counter == r_period_a) begin
                w_counter_next = '0;
                w_boundary     = 1'b1;
            end else begin
                w_counter_next = r_counter + 1'b1;
            end
            w_dir_next = DIR_UP;
        end else begin
            // Triangle: climb to P, turn round, descend to 0.
            // Reaching 0 closes the period, which gives 2*P steps per period.
            if (r_dir == DIR_UP) begin
                if (r_counter == r_period_a) begin
                    w_counter_next = r_counter - 1'b1;
                    w_dir_next     = DIR_DOWN;
                end else begin
                    w_counter_next = r_counter + 1'b1;
                end
            end else begin
                w_counter_next = r_counter - 1'b1;
            end
            if (w_counter_next == '0) begin
                w_boundary = 1'b1;
                w_dir_next = DIR_UP;
            end
        end
    end

    // Timebase registers.
    // Period and mode are picked up only at a boundary.
    // period_done is a one-cycle pulse in the cycle after each boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter     <= '0;
            r_dir         <= DIR_UP;
            r_period_a    <= '0;
            r_mode_a      <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_period_done <= w_boundary_take;
            if (w_advance) begin
                r_counter <= w_counter_next;
                r_dir     <= w_dir_next;
            end
            if (w_boundary_take) begin
                r_period_a <= period;
                r_mode_a   <= mode;
            end
        end
    end

    assign period_done = r_period_done;

    // Per-channel duty storage and compare.
    // An address with no matching channel simply hits nothing, so
    // out-of-range writes are dropped without a separate range check.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic         w_wr_hit;
        logic [N-1:0] r_shadow;
        logic [N-1:0] r_active;

        assign w_wr_hit = wr_ena && (wr_addr == AW'(gi));

        // Shadow takes every write.
        // Active reloads from the shadow at a boundary, or takes the
        // incoming write directly when both happen on the same edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_shadow <= '0;
                r_active <= '0;
            end else begin
                if (w_wr_hit) begin
                    r_shadow <= wr_duty;
                end
                if (w_boundary_take) begin
                    r_active <= w_wr_hit ? wr_duty : r_shadow;
                end
            end
        end

        // A duty of 0 never drives the output high.
        // A duty above the period drives it high for the whole period,
        // because the counter never exceeds the period.
        assign out[gi] = ena & (r_counter < r_active);
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed scenarios followed by randomized traffic for pwm_multi.
// The reference model tracks the step index within the current period.
// It derives the counter value from that index, so it never steps a
// counter/direction pair the way the design does.

module tb_pwm_multi;

    localparam int N  = 8;
    localparam int CH = 5;              // 5 channels leave addresses 5..7 unused
    localparam int AW = $clog2(CH);

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          step;
    logic [N-1:0]  period;
    logic          mode;
    logic          wr_ena;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_duty;
    logic [CH-1:0] out;
    logic          period_done;

    always #5 clk = ~clk;

    pwm_multi #(
        .N        (N),
        .CHANNELS (CH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .step        (step),
        .period      (period),
        .mode        (mode),
        .wr_ena      (wr_ena),
        .wr_addr     (wr_addr),
        .wr_duty     (wr_duty),
        .out         (out),
        .period_done (period_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_k  = 0;               // step index within the current period
    int m_pa = 0;               // active period
    bit m_ma = 1'b0;            // active mode
    bit m_pd = 1'b0;            // expected period_done
    int m_s[CH];                // shadow duties
    int m_a[CH];                // active duties

    // Period and mode currently presented on the inputs.
    logic [N-1:0] g_period = '0;
    logic         g_mode   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Counter value implied by the step index within the period.
    function automatic int model_count();
        if (m_pa == 0) return 0;
        if (!m_ma) return m_k;
        return (m_k <= m_pa) ? m_k : 2 * m_pa - m_k;
    endfunction

    // Apply one cycle of inputs (called at a falling edge).
    // Advance the model on the rising edge.
    // Compare outputs at the next falling edge.
    task automatic do_cycle(input logic t_rst, input logic t_ena, input logic t_step,
                            input logic t_wr, input logic [AW-1:0] t_addr,
                            input logic [N-1:0] t_duty);
        logic [CH-1:0] e_out;
        int            len;
        bit            bnd;
        rst     = t_rst;
        ena     = t_ena;
        step    = t_step;
        period  = g_period;
        mode    = g_mode;
        wr_ena  = t_wr;
        wr_addr = t_addr;
        wr_duty = t_duty;
        @(posedge clk);
        if (t_rst) begin
            m_k  = 0;
            m_pa = 0;
            m_ma = 1'b0;
            m_pd = 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_s[i] = 0;
                m_a[i] = 0;
            end
        end else begin
            bnd = 1'b0;
            if (t_ena && t_step) begin
                len = (m_pa == 0) ? 1 : (m_ma ? 2 * m_pa : m_pa + 1);
                m_k = (m_k + 1) % len;
                bnd = (m_k == 0);
            end
            if (t_wr && int'(t_addr) < CH) m_s[t_addr] = int'(t_duty);
            if (bnd) begin
                m_pa = int'(g_period);
                m_ma = g_mode;
                for (int i = 0; i < CH; i++) m_a[i] = m_s[i];
            end
            m_pd = bnd;
        end
        @(negedge clk);
        for (int i = 0; i < CH; i++) e_out[i] = t_ena && (model_count() < m_a[i]);
        check_eq("out", 32'(out), 32'(e_out));
        check_eq("period_done", 32'(period_done), 32'(m_pd));
        $display("t=%0t rst=%b ena=%b step=%b per=%0d mode=%b wr=%b addr=%0d duty=%0d cnt=%0d out=%b pd=%b",
                 $time, t_rst, t_ena, t_step, g_period, g_mode, t_wr, t_addr, t_duty,
                 model_count(), out, period_done);
    endtask

    task automatic run_steps(input int n, input logic t_ena, input logic t_step);
        repeat (n) do_cycle(1'b0, t_ena, t_step, 1'b0, '0, '0);
    endtask

    initial begin
        int hi0;
        int hi1;
        int pulses;
        int any_out;

        rst = 1'b1; ena = 1'b0; step = 1'b0; period = '0; mode = 1'b0;
        wr_ena = 1'b0; wr_addr = '0; wr_duty = '0;
        for (int i = 0; i < CH; i++) begin
            m_s[i] = 0;
            m_a[i] = 0;
        end
        @(negedge clk);

        // Reset, including reset winning over enable, step and write.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 8'd9);
        check_eq("reset_out", 32'(out), 32'd0);
        check_eq("reset_pd", 32'(period_done), 32'd0);

        // Edge mode, P=9, duty 4: 4 of 10 steps high, one pulse per 10 cycles.
        do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'd4);
        g_period = 8'd9; g_mode = 1'b0;
        run_steps(1, 1'b1, 1'b1);
        hi0 = 0; pulses = 0;
        for (int c = 0; c < 30; c++) begin
            run_steps(1, 1'b1, 1'b1);
            hi0 += int'(out[0]);
            pulses += int'(period_done);
        end
        check_eq("edge_duty_highs", 32'(hi0), 32'd12);
        check_eq("edge_pulses", 32'(pulses), 32'd3);

        // Center mode, P=3, duty 2: high at counter 0 and 1, pulse per 6 steps.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        g_period = 8'd3; g_mode = 1'b1;
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'd2);
        hi1 = 0; pulses = 0;
        for (int c = 0; c < 12; c++) begin
            run_steps(1, 1'b1, 1'b1);
            hi1 += int'(out[1]);
            pulses += int'(period_done);
        end
        check_eq("center_duty_highs", 32'(hi1), 32'd6);
        check_eq("center_pulses", 32'(pulses), 32'd2);

        // A mid-period write is held back; a boundary-cycle write takes effect at once.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        g_period = 8'd9; g_mode = 1'b0;
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'd3);     // boundary, counter 0
        run_steps(5, 1'b1, 1'b1);                          // counter 5
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'd7);     // counter 6
        check_eq("midwrite_hold_c6", 32'(out[2]), 32'd0);
        run_steps(1, 1'b1, 1'b1);                          // counter 7
        check_eq("midwrite_hold_c7", 32'(out[2]), 32'd0);
        run_steps(2, 1'b1, 1'b1);                          // counter 9
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'd0);     // boundary with write
        check_eq("bypass_c0", 32'(out[2]), 32'd0);
        run_steps(1, 1'b1, 1'b1);
        check_eq("bypass_c1", 32'(out[2]), 32'd0);

        // Duty 0 stays low and duty 10 stays high across 3 periods at P=9.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        g_period = 8'd9; g_mode = 1'b0;
        do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'd5);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'd10);    // boundary
        hi0 = 0; hi1 = 0;
        for (int c = 0; c < 30; c++) begin
            run_steps(1, 1'b1, 1'b1);
            hi0 += int'(out[2]);
            hi1 += int'(out[1]);
        end
        check_eq("duty0_highs", 32'(hi0), 32'd0);
        check_eq("duty10_highs", 32'(hi1), 32'd30);

        // Drop ena for 5 cycles mid-period; counter resumes from 3.
        run_steps(3, 1'b1, 1'b1);                          // counter 3
        pulses = 0; any_out = 0;
        for (int c = 0; c < 5; c++) begin
            run_steps(1, 1'b0, 1'b1);
            pulses += int'(period_done);
            any_out += (out != '0) ? 1 : 0;
        end
        check_eq("ena_low_pulses", 32'(pulses), 32'd0);
        check_eq("ena_low_out", 32'(any_out), 32'd0);
        run_steps(1, 1'b1, 1'b1);
        check_eq("resume_c4", 32'(out[0]), 32'd1);
        run_steps(1, 1'b1, 1'b1);
        check_eq("resume_c5", 32'(out[0]), 32'd0);

        // Reset in center mode while counting down.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        g_period = 8'd4; g_mode = 1'b1;
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'd2);     // boundary
        run_steps(5, 1'b1, 1'b1);                          // 1,2,3,4,3 (down)
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 8'd9);
        check_eq("midreset_out", 32'(out), 32'd0);
        check_eq("midreset_pd", 32'(period_done), 32'd0);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'd2);     // boundary, counter 0
        run_steps(1, 1'b1, 1'b1);                          // counter 1, going up
        check_eq("post_reset_up", 32'(out[3]), 32'd1);

        // Full-range edge period: all-ones wraps to 0 as a normal boundary.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        g_period = 8'hFF; g_mode = 1'b0;
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF);
        pulses = 0;
        for (int c = 0; c < 256; c++) begin
            run_steps(1, 1'b1, 1'b1);
            pulses += int'(period_done);
        end
        check_eq("wrap_pulses", 32'(pulses), 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 1200; c++) begin
            logic          r_rst;
            logic          r_ena;
            logic          r_step;
            logic          r_wr;
            logic [AW-1:0] r_addr;
            logic [N-1:0]  r_duty;
            if ($urandom_range(0, 19) == 0) begin
                g_period = ($urandom_range(0, 9) == 0) ? 8'hFF : N'($urandom_range(0, 12));
                g_mode   = 1'($urandom_range(0, 1));
            end
            r_rst  = ($urandom_range(0, 199) == 0);
            r_ena  = ($urandom_range(0, 9) != 0);
            r_step = ($urandom_range(0, 9) < 7);
            r_wr   = ($urandom_range(0, 9) < 3);
            r_addr = AW'($urandom_range(0, 7));
            r_duty = ($urandom_range(0, 15) == 0) ? 8'hFF : N'($urandom_range(0, 14));
            do_cycle(r_rst, r_ena, r_step, r_wr, r_addr, r_duty);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 Parameter N, default 8: counter, period and duty width in bits.
REQ-002 Parameter CHANNELS, default 4: number of independent PWM outputs sharing one counter; must be >= 2.
REQ-003 Parameter AW, default $clog2(CHANNELS): channel address width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 ena  input  1  global enable; low freezes the counter and forces every output low.
REQ-007 step  input  1  counter advance strobe; the counter moves only on cycles with ena=1 and step=1.
REQ-008 period  input  N  requested period value P; sampled only at a period boundary.
REQ-009 mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled only at a period boundary.
REQ-010 wr_ena  input  1  duty write strobe.
REQ-011 wr_addr  input  AW  channel selected by wr_ena; addresses >= CHANNELS are ignored.
REQ-012 wr_duty  input  N  new duty value for the selected channel.
REQ-013 out  output  CHANNELS  PWM outputs, one bit per channel.
REQ-014 period_done  output  1  one-cycle pulse marking each period boundary.

Function
REQ-015 State: counter[N-1:0]; dir (up/down); active period P_a; active mode M_a; per-channel shadow duty S[i] and active duty A[i].
REQ-016 out[i] = ena & (counter < A[i]) for each channel, combinational from registered state with no added latency.
REQ-017 Duty rules: A[i]=0 gives a constant-low output; A[i] > P_a gives a constant-high output for the whole period.
REQ-018 Writes: wr_ena=1 with a valid wr_addr loads S[wr_addr] <= wr_duty at the clock edge; writes are accepted regardless of ena and step.
REQ-019 Edge mode, advance: if counter == P_a then counter <= 0 (boundary), else counter <= counter+1; period length is P_a+1 steps.
REQ-020 Center mode, advance with dir=up: if counter == P_a then counter <= counter-1 and dir <= down, else counter <= counter+1.
REQ-021 Center mode, advance with dir=down: counter <= counter-1.
REQ-022 Center mode boundary: any advance whose next counter value is 0 is a boundary and sets dir <= up; period length is 2*P_a steps (e.g. P_a=3 gives 0,1,2,3,2,1,0).
REQ-023 P_a = 0, either mode: the counter stays 0 and every advance is a boundary.
REQ-024 At a boundary, in the same edge: P_a <= period, M_a <= mode, and A[i] <= S[i] for all i.
REQ-025 A write to channel k in the same cycle as a boundary makes A[k] take wr_duty directly (bypass); S[k] also takes wr_duty.
REQ-026 period_done is a registered pulse, high for exactly one cycle, in the cycle after each boundary edge.
REQ-027 ena=0: counter, dir, P_a, M_a and A hold; period_done=0; out=0; step is ignored.
REQ-028 Counter arithmetic is modulo 2^N; with P = 2^N-1 in edge mode the counter wraps from all-ones to 0 as a normal boundary.

Reset
REQ-029 When rst=1 at a clock edge: counter=0, dir=up, P_a=0, M_a=0, all S[i]=0, all A[i]=0, period_done=0; consequently out=0 in the following cycle.
REQ-030 rst overrides ena, step and wr_ena in the same cycle; reset mid-period abandons the period with no boundary pulse.
REQ-031 By REQ-023, the first advance after reset is a boundary that latches period, mode and all shadow duties.

Verification
REQ-032 Reset, write S[0]=4, set period=9, mode=0, then run step every cycle -> out[0] high for 4 of every 10 steps; period_done pulses every 10 cycles.
REQ-033 Center mode with period=3 and S[1]=2 -> counter sequence 0,1,2,3,2,1,0; out[1] high at counter 0 and 1; period_done once per 6 steps.
REQ-034 Write S[2]=7 mid-period -> out[2] is unchanged until the next boundary; write on the boundary cycle itself -> the new value takes effect immediately (bypass).
REQ-035 Duty 0 and duty 10 with P=9 -> out constant low and constant high respectively across 3 full periods.
REQ-036 Drop ena mid-period for 5 cycles -> out=0, counter frozen, no period_done; on resume the counter continues from its held value.
REQ-037 Assert rst mid-period in center mode with dir=down -> next cycle counter=0, dir=up, out=0, no period_done pulse.
